// File: rtl/palette_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// palette_wr_arbiter_if
// Bundles the requester handshakes, the clear control and the palette RAM
// write port that palette_wr_arbiter owns.
//   a_* / b_*      : requester A / B (valid, ready, address, data)
//   clear_*        : full-palette clear request, value, busy flag, done pulse
//   wr_*           : palette RAM write port plus the owner tag of wr_req
// master : requester / controller side (drives valids, clear_start)
// slave  : arbiter side (drives readies, clear status, RAM write port)
// ---------------------------------------------------------------------------
interface palette_wr_arbiter_if #(
  parameter int ram_width  = 8,
  parameter int data_width = 12
);
  logic                  a_valid;
  logic                  a_ready;
  logic [ram_width-1:0]  a_add;
  logic [data_width-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ram_width-1:0]  b_add;
  logic [data_width-1:0] b_data;
  logic                  clear_start;
  logic [data_width-1:0] clear_value;
  logic                  clear_busy;
  logic                  clear_done;
  logic [ram_width-1:0]  wr_add;
  logic [data_width-1:0] wr_data;
  logic                  wr_req;
  logic [1:0]            wr_owner;

  modport master (
    output a_valid, a_add, a_data, b_valid, b_add, b_data,
    output clear_start, clear_value,
    input  a_ready, b_ready, clear_busy, clear_done,
    input  wr_add, wr_data, wr_req, wr_owner
  );

  modport slave (
    input  a_valid, a_add, a_data, b_valid, b_add, b_data,
    input  clear_start, clear_value,
    output a_ready, b_ready, clear_busy, clear_done,
    output wr_add, wr_data, wr_req, wr_owner
  );
endinterface

// File: rtl/palette_wr_arbiter.sv
// ---------------------------------------------------------------------------
// palette_wr_arbiter
// Owns the write port of the palette RAM and shares it between requesters A
// and B with round-robin arbitration. A clear sequencer sweeps every entry to
// one value, either on clear_start or automatically after reset.
// Ports:
//   clk  : RAM write clock, all logic on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : palette_wr_arbiter_if.slave (requesters, clear control, RAM port)
// Writes are registered: a grant in cycle N shows up on wr_* in cycle N+1.
// ---------------------------------------------------------------------------
module palette_wr_arbiter #(
  parameter int                    ram_width      = 8,
  parameter int                    data_width     = 12,
  parameter bit                    clear_on_reset = 1'b0,
  parameter logic [data_width-1:0] init_value     = {data_width{1'b0}}
) (
  input logic                clk,
  input logic                rst,
  palette_wr_arbiter_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;
  localparam logic [1:0] OWN_CLR  = 2'b11;
  localparam logic       GRANT_A  = 1'b0;
  localparam logic       GRANT_B  = 1'b1;
  localparam logic [ram_width-1:0] CNT_ZERO = {ram_width{1'b0}};
  localparam logic [ram_width-1:0] CNT_LAST = {ram_width{1'b1}};
  localparam logic [ram_width-1:0] CNT_ONE  = {{(ram_width-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ram_width-1:0]  cnt_q, cnt_d;
  logic [data_width-1:0] clr_val_q, clr_val_d;
  logic                  pend_q, pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_req_q, wr_req_d;
  logic [ram_width-1:0]  wr_add_q, wr_add_d;
  logic [data_width-1:0] wr_data_q, wr_data_d;
  logic [1:0]            owner_q, owner_d;
  logic                  start_req;
  logic                  a_rdy;
  logic                  b_rdy;

  // Next-state, grant and write-port selection.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    clr_val_d    = clr_val_q;
    pend_d       = 1'b0;           // post-reset clear request lasts one cycle
    busy_d       = busy_q;
    done_d       = 1'b0;
    wr_req_d     = 1'b0;
    wr_add_d     = wr_add_q;       // address/data hold when nothing is written
    wr_data_d    = wr_data_q;
    owner_d      = OWN_NONE;
    a_rdy        = 1'b0;
    b_rdy        = 1'b0;
    start_req    = bus.clear_start | pend_q;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          // Clear beats any simultaneous request; the automatic post-reset
          // clear uses init_value instead of the sampled clear_value.
          state_d   = S_CLEAR;
          busy_d    = 1'b1;
          cnt_d     = CNT_ZERO;
          clr_val_d = pend_q ? init_value : bus.clear_value;
        end else begin
          // Round robin on a tie: grant whoever did not win last time.
          a_rdy = bus.a_valid & (~bus.b_valid | (last_grant_q == GRANT_B));
          b_rdy = bus.b_valid & (~bus.a_valid | (last_grant_q == GRANT_A));
          if (a_rdy) begin
            last_grant_d = GRANT_A;
            wr_req_d     = 1'b1;
            wr_add_d     = bus.a_add;
            wr_data_d    = bus.a_data;
            owner_d      = OWN_A;
          end else if (b_rdy) begin
            last_grant_d = GRANT_B;
            wr_req_d     = 1'b1;
            wr_add_d     = bus.b_add;
            wr_data_d    = bus.b_data;
            owner_d      = OWN_B;
          end else begin
            wr_req_d = 1'b0;
          end
        end
      end
      S_CLEAR: begin
        wr_req_d  = 1'b1;
        wr_add_d  = cnt_q;
        wr_data_d = clr_val_q;
        owner_d   = OWN_CLR;
        // Stop on the last address rather than wrapping into a second pass;
        // done is registered so it lines up with the final write.
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, sweep and registered write-port flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_B;
      cnt_q        <= CNT_ZERO;
      clr_val_q    <= {data_width{1'b0}};
      pend_q       <= clear_on_reset;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_add_q     <= CNT_ZERO;
      wr_data_q    <= {data_width{1'b0}};
      owner_q      <= OWN_NONE;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      clr_val_q    <= clr_val_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_req_q     <= wr_req_d;
      wr_add_q     <= wr_add_d;
      wr_data_q    <= wr_data_d;
      owner_q      <= owner_d;
    end
  end

  assign bus.a_ready    = a_rdy;
  assign bus.b_ready    = b_rdy;
  assign bus.clear_busy = busy_q;
  assign bus.clear_done = done_q;
  assign bus.wr_req     = wr_req_q;
  assign bus.wr_add     = wr_add_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_owner   = owner_q;

endmodule

// File: tb/tb_palette_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_palette_wr_arbiter
// Directed bench for palette_wr_arbiter: reset values, round robin, single
// write latency, clear sweep with a competing request and an ignored restart,
// reset in the middle of a sweep, and the automatic clear after reset.
// ---------------------------------------------------------------------------
module tb_palette_wr_arbiter;
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  palette_wr_arbiter_if #(.ram_width(8), .data_width(12)) bus ();
  palette_wr_arbiter_if #(.ram_width(8), .data_width(12)) bus2 ();

  palette_wr_arbiter #(.ram_width(8), .data_width(12), .clear_on_reset(1'b0),
                       .init_value(12'h000))
    dut (.clk(clk), .rst(rst), .bus(bus));

  palette_wr_arbiter #(.ram_width(8), .data_width(12), .clear_on_reset(1'b1),
                       .init_value(12'h000))
    dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %0h expected 0", bus.wr_req); end
    checks++; if (bus.wr_add !== 8'h00) begin errors++; $display("FAIL reset_wr_add: got %0h expected 00", bus.wr_add); end
    checks++; if (bus.wr_data !== 12'h000) begin errors++; $display("FAIL reset_wr_data: got %0h expected 000", bus.wr_data); end
    checks++; if (bus.wr_owner !== 2'b00) begin errors++; $display("FAIL reset_wr_owner: got %0h expected 0", bus.wr_owner); end
    checks++; if (bus.clear_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", bus.clear_busy); end
    checks++; if (bus.clear_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0h expected 0", bus.clear_done); end
    checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b%0b expected 00", bus.a_ready, bus.b_ready); end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    bus.a_valid = 1'b1; bus.a_add = 8'h10; bus.a_data = 12'hAAA;
    bus.b_valid = 1'b1; bus.b_add = 8'h20; bus.b_data = 12'hBBB;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      checks++; if (bus.a_ready !== exp_a || bus.b_ready !== !exp_a) begin errors++; $display("FAIL rr_ready[%0d]: got a=%0b b=%0b expected a=%0b", i, bus.a_ready, bus.b_ready, exp_a); end
      tick();
      checks++; if (bus.wr_req !== 1'b1 || bus.wr_owner !== (exp_a ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_owner[%0d]: got req=%0b owner=%0b expected owner=%0b", i, bus.wr_req, bus.wr_owner, exp_a ? 2'b01 : 2'b10); end
      checks++; if (bus.wr_add !== (exp_a ? 8'h10 : 8'h20) || bus.wr_data !== (exp_a ? 12'hAAA : 12'hBBB)) begin errors++; $display("FAIL rr_data[%0d]: got %0h/%0h", i, bus.wr_add, bus.wr_data); end
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_a();
    bus.a_valid = 1'b1; bus.a_add = 8'h05; bus.a_data = 12'h123;
    #1;
    checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin errors++; $display("FAIL single_ready: got a=%0b b=%0b expected a=1 b=0", bus.a_ready, bus.b_ready); end
    tick();
    bus.a_valid = 1'b0;
    checks++; if (bus.wr_req !== 1'b1 || bus.wr_owner !== 2'b01) begin errors++; $display("FAIL single_req: got req=%0b owner=%0b expected 1/01", bus.wr_req, bus.wr_owner); end
    checks++; if (bus.wr_add !== 8'h05 || bus.wr_data !== 12'h123) begin errors++; $display("FAIL single_data: got %0h/%0h expected 05/123", bus.wr_add, bus.wr_data); end
    tick();
    checks++; if (bus.wr_req !== 1'b0 || bus.wr_owner !== 2'b00) begin errors++; $display("FAIL single_idle: got req=%0b owner=%0b expected 0/00", bus.wr_req, bus.wr_owner); end
    checks++; if (bus.wr_add !== 8'h05 || bus.wr_data !== 12'h123) begin errors++; $display("FAIL single_hold: got %0h/%0h expected 05/123", bus.wr_add, bus.wr_data); end
  endtask

  task automatic test_clear_with_a();
    int nclr = 0;
    int ndone = 0;
    logic exp_req, exp_busy, exp_done, exp_ar;
    logic [1:0] exp_own;
    logic [7:0] exp_add;
    logic [11:0] exp_data;
    bus.a_valid = 1'b1; bus.a_add = 8'h33; bus.a_data = 12'h456;
    bus.clear_start = 1'b1; bus.clear_value = 12'h000;
    #1;
    checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL clr_start_ready: got %0b expected 0", bus.a_ready); end
    for (int c = 1; c <= 258; c++) begin
      tick();
      if (c == 1) bus.clear_start = 1'b0;
      exp_req  = (c >= 2);
      exp_busy = (c <= 256);
      exp_done = (c == 257);
      exp_ar   = (c >= 257);
      exp_own  = (c == 1) ? 2'b00 : ((c <= 257) ? 2'b11 : 2'b01);
      exp_add  = (c <= 257) ? 8'(c - 2) : 8'h33;
      exp_data = (c <= 257) ? 12'h000 : 12'h456;
      if (bus.wr_req === 1'b1 && bus.wr_owner === 2'b11) nclr++;
      if (bus.clear_done === 1'b1) ndone++;
      checks++; if (bus.wr_req !== exp_req || bus.wr_owner !== exp_own) begin errors++; $display("FAIL clr_req[%0d]: got req=%0b owner=%0b expected %0b/%0b", c, bus.wr_req, bus.wr_owner, exp_req, exp_own); end
      if (exp_req) begin
        checks++; if (bus.wr_add !== exp_add || bus.wr_data !== exp_data) begin errors++; $display("FAIL clr_data[%0d]: got %0h/%0h expected %0h/%0h", c, bus.wr_add, bus.wr_data, exp_add, exp_data); end
      end
      checks++; if (bus.clear_busy !== exp_busy || bus.clear_done !== exp_done) begin errors++; $display("FAIL clr_flags[%0d]: got busy=%0b done=%0b expected %0b/%0b", c, bus.clear_busy, bus.clear_done, exp_busy, exp_done); end
      checks++; if (bus.a_ready !== exp_ar) begin errors++; $display("FAIL clr_a_ready[%0d]: got %0b expected %0b", c, bus.a_ready, exp_ar); end
      if (c == 100) bus.clear_start = 1'b1;
      if (c == 101) bus.clear_start = 1'b0;
      if (c == 258) bus.a_valid = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.wr_req === 1'b1 && bus.wr_owner === 2'b11) nclr++;
      if (bus.clear_done === 1'b1) ndone++;
    end
    checks++; if (nclr != 256) begin errors++; $display("FAIL clr_write_count: got %0d expected 256", nclr); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL clr_done_count: got %0d expected 1", ndone); end
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 1'b0;
    int nreq = 0;
    int ndone = 0;
    bus.clear_start = 1'b1; bus.clear_value = 12'hFFF;
    tick();
    bus.clear_start = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (bus.wr_req === 1'b1 && bus.wr_owner === 2'b11 && bus.wr_add === 8'h40) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach40: got timeout expected sweep at 40"); end
    rst = 1'b1;
    #1;
    checks++; if (bus.wr_req !== 1'b0 || bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got req=%0b busy=%0b done=%0b expected 000", bus.wr_req, bus.clear_busy, bus.clear_done); end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (bus.wr_req === 1'b1) nreq++;
      if (bus.clear_done === 1'b1) ndone++;
    end
    checks++; if (nreq != 0 || ndone != 0) begin errors++; $display("FAIL midrst_quiet: got writes=%0d done=%0d expected 0/0", nreq, ndone); end
    bus.a_valid = 1'b1; bus.a_add = 8'h7E; bus.a_data = 12'h0AB;
    #1;
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL midrst_a_ready: got %0b expected 1", bus.a_ready); end
    tick();
    bus.a_valid = 1'b0;
    checks++; if (bus.wr_req !== 1'b1 || bus.wr_owner !== 2'b01 || bus.wr_add !== 8'h7E || bus.wr_data !== 12'h0AB) begin errors++; $display("FAIL midrst_a_write: got req=%0b owner=%0b %0h/%0h expected 1/01 7e/0ab", bus.wr_req, bus.wr_owner, bus.wr_add, bus.wr_data); end
  endtask

  task automatic test_clear_on_reset();
    int nclr = 0;
    int ndone = 0;
    logic exp_req, exp_done;
    rst2 = 1'b0;
    for (int c = 1; c <= 260; c++) begin
      tick();
      exp_req  = (c >= 2 && c <= 257);
      exp_done = (c == 257);
      if (bus2.wr_req === 1'b1 && bus2.wr_owner === 2'b11) nclr++;
      if (bus2.clear_done === 1'b1) ndone++;
      checks++; if (bus2.wr_req !== exp_req || bus2.clear_done !== exp_done) begin errors++; $display("FAIL cor_req[%0d]: got req=%0b done=%0b expected %0b/%0b", c, bus2.wr_req, bus2.clear_done, exp_req, exp_done); end
      if (exp_req) begin
        checks++; if (bus2.wr_add !== 8'(c - 2) || bus2.wr_data !== 12'h000 || bus2.wr_owner !== 2'b11) begin errors++; $display("FAIL cor_data[%0d]: got %0h/%0h owner=%0b expected %0h/000/11", c, bus2.wr_add, bus2.wr_data, bus2.wr_owner, 8'(c - 2)); end
      end
    end
    checks++; if (nclr != 256 || ndone != 1) begin errors++; $display("FAIL cor_counts: got writes=%0d done=%0d expected 256/1", nclr, ndone); end
  endtask

  initial begin
    bus.a_valid = 1'b0; bus.a_add = 8'h00; bus.a_data = 12'h000;
    bus.b_valid = 1'b0; bus.b_add = 8'h00; bus.b_data = 12'h000;
    bus.clear_start = 1'b0; bus.clear_value = 12'h000;
    bus2.a_valid = 1'b0; bus2.a_add = 8'h00; bus2.a_data = 12'h000;
    bus2.b_valid = 1'b0; bus2.b_add = 8'h00; bus2.b_data = 12'h000;
    bus2.clear_start = 1'b0; bus2.clear_value = 12'h5A5;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_round_robin();
    test_single_a();
    test_clear_with_a();
    test_reset_mid_sweep();
    test_clear_on_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
